// File: rtl/joypad_port_pkg.sv
// joypad_port_pkg: register addresses, button bit indices and scanner state encoding
package joypad_port_pkg;
  localparam logic [15:0] ADDR_PAD0 = 16'h4016;
  localparam logic [15:0] ADDR_PAD1 = 16'h4017;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/joypad_scanner.sv
// joypad_scanner: autonomous latch/clock/data scanner for two serial pads
module joypad_scanner
  import joypad_port_pkg::*;
#(
  parameter logic [15:0] HALF_PERIOD = 16'd256,
  parameter logic [15:0] POLL_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] snap0,
  output logic [7:0] snap1
);
  logic [2:0] state;
  logic [2:0] idx;
  logic [15:0] cnt;
  logic [15:0] len;
  logic last;
  logic [7:0] acc0, acc1;
  always_comb len = state == S_IDLE ? POLL_CYCLES : state == S_LATCH ? {HALF_PERIOD[14:0], 1'b0} : HALF_PERIOD;
  assign last = cnt == len - 16'd1;
  assign pad_latch = state == S_LATCH;
  assign pad_clk = state == S_HIGH;
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      acc0 <= '0;
      acc1 <= '0;
      snap0 <= '0;
      snap1 <= '0;
    end else begin
      cnt <= (last || state == S_DONE) ? '0 : cnt + 16'd1;
      if (state == S_DONE) begin
        snap0 <= acc0;
        snap1 <= acc1;
        state <= S_IDLE;
      end else if (last) begin
        state <= state == S_IDLE ? S_LATCH : state == S_LATCH ? S_LOW : state == S_LOW ? S_HIGH : idx == 3'd7 ? S_DONE : S_LOW;
        if (state == S_LATCH) idx <= '0;
        if (state == S_HIGH) idx <= idx + 3'd1;
        if (state == S_LOW) begin
          acc0[idx] <= ~pad_data[0];
          acc1[idx] <= ~pad_data[1];
        end
      end
    end
endmodule

// File: rtl/joypad_port.sv
// joypad_port: NES $4016/$4017 controller registers backed by a pad scanner
module joypad_port
  import joypad_port_pkg::*;
#(
  parameter logic [15:0] HALF_PERIOD = 16'd256,
  parameter logic [15:0] POLL_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        mr,
  input  logic        mw,
  output logic [7:0]  dout,
  output logic        sel,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic [1:0]  pad_data
);
  logic strobe;
  logic hit0, hit1, b;
  logic [7:0] sr0, sr1, snap0, snap1;
  logic unused_din;
  assign unused_din = ^din[7:1];
  assign hit0 = addr == ADDR_PAD0;
  assign hit1 = addr == ADDR_PAD1;
  assign sel = (hit0 || hit1) && mr;
  always_comb b = hit1 ? (strobe ? snap1[BTN_A] : sr1[0]) : (strobe ? snap0[BTN_A] : sr0[0]);
  assign dout = {7'b0100000, b};
  always_ff @(posedge clk)
    if (reset) begin
      strobe <= 1'b0;
      sr0 <= '0;
      sr1 <= '0;
    end else if (ce) begin
      if (mw && hit0) strobe <= din[0];
      if (strobe) begin
        sr0 <= snap0;
        sr1 <= snap1;
      end else if (mr) begin
        if (hit0) sr0 <= {1'b1, sr0[7:1]};
        if (hit1) sr1 <= {1'b1, sr1[7:1]};
      end
    end
  joypad_scanner #(.HALF_PERIOD(HALF_PERIOD), .POLL_CYCLES(POLL_CYCLES)) u_scan (
    .clk(clk),
    .reset(reset),
    .pad_data(pad_data),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .snap0(snap0),
    .snap1(snap1)
  );
endmodule
